// File: rtl/debounce_pkg.sv
// Shared types and default constants for the switch debouncer.
package debounce_pkg;

  localparam int DB_CYCLES_10MS = 330000;  // 10 ms at 33 MHz
  localparam int DB_CNT_W       = 19;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } db_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop chain that brings an asynchronous level into the clk domain.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  // NOTE: non-blocking assignments let every stage capture its predecessor's
  // pre-edge value; blocking would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stages <= '0;
    else        stages <= {stages[SYNC_STAGES-2:0], d};
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_fsm.sv
// Debounces a raw switch: synchronizer, four-state qualification FSM, and
// a registered rising-edge tick aligned with the first high cycle of db_level.
module debounce_fsm
  import debounce_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_10MS,
  parameter int CNT_W       = DB_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  output logic db_level,
  output logic db_tick,
  output logic db_busy
);

  logic             sync_in;
  db_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tick_q, tick_nxt;
  logic             cnt_last;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw_in),
    .q     (sync_in)
  );

  assign cnt_last = (cnt == CNT_W'(DB_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ZERO;
      cnt    <= '0;
      tick_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      tick_q <= tick_nxt;
    end
  end

  // NOTE: every target gets a default up front so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ZERO: begin
        if (sync_in) begin
          state_nxt = WAIT1;
          cnt_nxt   = '0;
        end
      end
      WAIT1: begin
        if (!sync_in)      state_nxt = ZERO;
        else if (cnt_last) state_nxt = ONE;
        else               cnt_nxt   = cnt + CNT_W'(1);
      end
      ONE: begin
        if (!sync_in) begin
          state_nxt = WAIT0;
          cnt_nxt   = '0;
        end
      end
      WAIT0: begin
        if (sync_in)       state_nxt = ONE;
        else if (cnt_last) state_nxt = ZERO;
        else               cnt_nxt   = cnt + CNT_W'(1);
      end
      default: state_nxt = ZERO;
    endcase
    // Only a qualified press pulses; a bounce back from WAIT0 does not.
    tick_nxt = (state == WAIT1) && (state_nxt == ONE);
  end

  always_comb begin
    db_level = 1'b0;
    db_busy  = 1'b0;
    case (state)
      WAIT1:   db_busy  = 1'b1;
      ONE:     db_level = 1'b1;
      WAIT0: begin
        db_level = 1'b1;
        db_busy  = 1'b1;
      end
      default: ;
    endcase
    db_tick = tick_q;
  end

endmodule

// File: tb/tb_debounce_fsm.sv
// Self-checking bench for debounce_fsm using a run-length reference model.
module tb_debounce_fsm;

  localparam int DB  = 8;
  localparam int SS  = 2;
  localparam int CW  = 4;
  localparam int LAT = SS + DB + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sw_in = 1'b0;
  logic db_level, db_tick, db_busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: delay line of synchronizer samples, current accepted
  // level, and length of the current run of samples disagreeing with it.
  bit m_sync [SS];
  bit m_lvl;
  int m_run;
  bit m_tick;

  int   tick_cnt, rise_cnt, busy_cyc, high_cyc;
  logic prev_lvl;

  always #15 clk = ~clk;

  debounce_fsm #(
    .DB_CYCLES   (DB),
    .CNT_W       (CW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_in    (sw_in),
    .db_level (db_level),
    .db_tick  (db_tick),
    .db_busy  (db_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SS; i++) m_sync[i] = 1'b0;
    m_lvl  = 1'b0;
    m_run  = 0;
    m_tick = 1'b0;
  endtask

  // A new level is accepted after DB+1 consecutive disagreeing samples.
  task automatic model_edge();
    bit s;
    s      = m_sync[SS-1];
    m_tick = 1'b0;
    if (s == m_lvl) m_run = 0;
    else begin
      m_run++;
      if (m_run == DB + 1) begin
        m_lvl  = s;
        m_run  = 0;
        m_tick = s;
      end
    end
    for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = sw_in;
  endtask

  task automatic clear_stats();
    tick_cnt = 0;
    rise_cnt = 0;
    busy_cyc = 0;
    high_cyc = 0;
  endtask

  // Starts and ends just after a falling clock edge.
  task automatic step(input logic v);
    sw_in = v;
    @(posedge clk);
    if (reset) model_edge();
    #1;
    check("db_level", db_level, m_lvl);
    check("db_tick",  db_tick,  m_tick);
    check("db_busy",  db_busy,  (m_run > 0));
    if (db_tick === 1'b1) tick_cnt++;
    if (db_level === 1'b1 && prev_lvl !== 1'b1) rise_cnt++;
    if (db_busy === 1'b1) busy_cyc++;
    if (db_level === 1'b1) high_cyc++;
    prev_lvl = db_level;
    @(negedge clk);
  endtask

  // Edges until db_level reaches v; 40 means it never did.
  task automatic measure(input logic v, output int n);
    n = 40;
    for (int i = 1; i <= 40; i++) begin
      step(v);
      if (db_level === v) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic hold(input logic v, input int cycles);
    for (int i = 0; i < cycles; i++) step(v);
  endtask

  initial begin
    int n;
    model_reset();
    clear_stats();
    prev_lvl = 1'b0;
    sw_in    = 1'b1;
    @(negedge clk);

    // Reset held with the switch high, then released.
    hold(1'b1, 10);
    check("rst_high_cycles", high_cyc, 0);
    check("rst_busy_cycles", busy_cyc, 0);
    reset = 1'b1;
    clear_stats();
    measure(1'b1, n);
    check("rst_release_latency", n, LAT);
    hold(1'b1, 5);
    check("rst_release_ticks", tick_cnt, 1);

    // Clean release then clean press.
    clear_stats();
    measure(1'b0, n);
    check("release_latency", n, LAT);
    hold(1'b0, 30 - n);
    check("release_ticks", tick_cnt, 0);
    clear_stats();
    measure(1'b1, n);
    check("press_latency", n, LAT);
    hold(1'b1, 30 - n);
    check("press_ticks", tick_cnt, 1);
    check("press_busy_cycles", busy_cyc, DB);
    hold(1'b0, 20);

    // Bouncing press, also counted as a downstream edge detector would see it.
    clear_stats();
    for (int b = 0; b < 4; b++) begin
      hold(1'b1, 3);
      hold(1'b0, 2);
    end
    check("bounce_ticks", tick_cnt, 0);
    check("bounce_high_cycles", high_cyc, 0);
    measure(1'b1, n);
    check("bounce_final_latency", n, LAT);
    hold(1'b1, 10);
    check("bounce_total_ticks", tick_cnt, 1);
    check("bounce_level_rises", rise_cnt, 1);
    hold(1'b0, 20);

    // Pulse one sample short of acceptance, then exactly long enough.
    clear_stats();
    hold(1'b1, DB);
    hold(1'b0, 20);
    check("short_pulse_high", high_cyc, 0);
    check("short_pulse_busy", busy_cyc, DB);
    check("short_pulse_ticks", tick_cnt, 0);
    clear_stats();
    hold(1'b1, DB + 1);
    hold(1'b0, 25);
    check("min_pulse_ticks", tick_cnt, 1);
    check("min_pulse_rises", rise_cnt, 1);
    check("min_pulse_high", high_cyc, DB + 1);

    // Asynchronous reset in the middle of a qualification.
    hold(1'b1, SS + 5);
    check("pre_reset_busy", db_busy, 1'b1);
    #5 reset = 1'b0;
    #1;
    model_reset();
    check("async_reset_busy", db_busy, 1'b0);
    check("async_reset_level", db_level, 1'b0);
    @(negedge clk);
    hold(1'b1, 2);
    reset = 1'b1;
    measure(1'b1, n);
    check("reset_midwait_latency", n, LAT);

    // Random bursts with occasional mid-stream resets.
    for (int k = 0; k < 60; k++) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      hold(v, $urandom_range(1, 14));
      if ($urandom_range(0, 19) == 0) begin
        #3 reset = 1'b0;
        #1;
        model_reset();
        check("rand_async_reset_level", db_level, 1'b0);
        check("rand_async_reset_busy", db_busy, 1'b0);
        @(negedge clk);
        hold(v, 1);
        reset = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
